dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter F_WORD_N, default 32, meaning the total DDS frequency word width.
REQ-002 The block SHALL have parameter P_WORD_M, default 12, meaning the phase word width; FW = F_WORD_N-P_WORD_M is the f_ctrl width.
REQ-003 The block SHALL have parameter DWELL_W, default 16, meaning the dwell counter width.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port start, input, 1 bit: one-cycle sweep start request.
REQ-007 Port stop, input, 1 bit: abort request.
REQ-008 Port mode, input, 1 bit: 0 selects single up-sweep, 1 selects continuous triangle sweep.
REQ-009 Ports f_start, f_stop and f_step SHALL each be inputs of FW bits: the sweep endpoints and the increment.
REQ-010 Port dwell, input, DWELL_W bits: the number of cycles each frequency is held; a value of 0 SHALL be treated as 1.
REQ-011 Port p_base, input, P_WORD_M bits: the phase offset.
REQ-012 Port f_ctrl, output, FW bits: the frequency word driven to the DDS.
REQ-013 Port p_ctrl, output, P_WORD_M bits: the phase word driven to the DDS.
REQ-014 Port busy, output, 1 bit: high while a sweep is active.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a single sweep completes.
REQ-016 Port dir, output, 1 bit: 1 while stepping down.

Function
REQ-017 The FSM SHALL have states IDLE, UP, DOWN and FINISH.
REQ-018 In IDLE, start=1 and stop=0 SHALL, on the next edge:
- latch f_start, f_stop, f_step, dwell, mode and p_base;
- set f_ctrl=f_start and busy=1;
- load the dwell counter and enter UP.
REQ-019 start while busy=1 SHALL be ignored; latched configuration SHALL NOT change mid-sweep.
REQ-020 f_ctrl SHALL hold each value for exactly max(dwell,1) cycles before the next step.
REQ-021 UP step: the sum SHALL be computed in FW+1 bits. If f_ctrl+f_step >= f_stop, then f_ctrl=f_stop and the FSM enters FINISH (mode 0) or DOWN with dir=1 (mode 1). Otherwise f_ctrl=f_ctrl+f_step.
REQ-022 DOWN step: the difference SHALL be computed in FW+1 bits. If f_ctrl-f_step <= f_start or the subtraction underflows, then f_ctrl=f_start, dir=0 and the FSM enters UP. Otherwise f_ctrl=f_ctrl-f_step.
REQ-023 FINISH SHALL last one cycle with done=1, then return to IDLE with busy=0; f_ctrl SHALL hold f_stop.
REQ-024 If f_start >= f_stop, the first step SHALL land on f_stop per REQ-021; in mode 0, done SHALL occur after one dwell.
REQ-025 If f_step=0, f_ctrl SHALL stay at f_start until stop.
REQ-026 stop=1 in any non-IDLE state SHALL, on the next edge:
- enter IDLE with busy=0 and dir=0;
- hold f_ctrl at its current value;
- keep done=0.
REQ-027 stop and start asserted in the same cycle SHALL resolve as stop; the block SHALL remain or return to IDLE.
REQ-028 Without the REQ-033 option, p_ctrl SHALL equal the latched p_base, registered.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL enter IDLE with f_ctrl=0, p_ctrl=0, busy=0, done=0, dir=0 and the dwell counter at 0.
REQ-030 rst SHALL take priority over start and stop.
REQ-031 rst mid-sweep SHALL abort without a done pulse.

Configuration
REQ-032 Macro DDS_SWEEP_PHASE_STEP_EN SHALL compile an optional phase-step feature in or out.
REQ-033 With DDS_SWEEP_PHASE_STEP_EN defined:
- an input port p_step (P_WORD_M bits) SHALL be added and latched at start;
- p_ctrl SHALL start at p_base and add p_step, modulo 2^P_WORD_M, at every frequency step.
REQ-034 Without DDS_SWEEP_PHASE_STEP_EN, the p_step port SHALL NOT exist and REQ-028 SHALL apply.

Structure
REQ-035 A shared package dds_pkg SHALL hold:
- the FSM state enum sweep_state_t;
- default width constants for F_WORD_N, P_WORD_M and DWELL_W.
REQ-036 The dwell timer SHALL be a sub-module dds_dwell_timer with a load/expire interface.
REQ-037 The step arithmetic SHALL remain in dds_sweep_ctrl.

Verification
REQ-038 Single sweep: start, mode=0, f_start=100, f_stop=130, f_step=10, dwell=4 -> f_ctrl SHALL read 100,110,120,130 for 4 cycles each, then done pulses once and busy falls.
REQ-039 Clamp: f_start=0, f_stop=25, f_step=10, dwell=1 -> f_ctrl SHALL read 0,10,20,25, then done.
REQ-040 Triangle: mode=1, f_start=0, f_stop=20, f_step=10, dwell=1 -> f_ctrl SHALL repeat 0,10,20,10,0,10 with dir high on the 20->0 leg and no done pulse.
REQ-041 Underflow: mode=1, f_start=5, f_stop=(2^FW)-1, f_step=2^(FW-1) -> the down leg SHALL clamp to 5 with no wrap.
REQ-042 Abort: stop during the third dwell of the REQ-038 sweep -> next cycle busy=0, f_ctrl=120, done never asserted; start during the sweep has no effect; rst mid-sweep SHALL give all outputs 0.
REQ-043 Option: with DDS_SWEEP_PHASE_STEP_EN, p_base=4090, p_step=4, P_WORD_M=12 -> p_ctrl SHALL read 4090, 4094, 2 on successive steps.

Source files
------------

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sweep controller:
//   - sweep_state_t : sweep FSM state encoding
//   - DEF_*         : default widths for the frequency word, phase word and
//                     dwell counter
// ---------------------------------------------------------------------------
package dds_pkg;

  localparam int DEF_F_WORD_N = 32;
  localparam int DEF_P_WORD_M = 12;
  localparam int DEF_DWELL_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    FINISH = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// ---------------------------------------------------------------------------
// dds_dwell_timer
// Counts how long the current frequency has been held.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (counter to 0)
//   load   - start a new hold period of max(dwell,1) cycles
//   dwell  - hold length in cycles (0 behaves as 1)
//   expire - high in the last cycle of the hold period
// ---------------------------------------------------------------------------
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_r;

  // Down-counter holding the remaining cycles minus one; a zero dwell loads 0
  // so that the very next edge already sees the period as expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= (dwell == '0) ? '0 : (dwell - DWELL_W'(1));
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - DWELL_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency sweep controller for a DDS. Steps the frequency word from f_start
// towards f_stop by f_step, holding each value for max(dwell,1) cycles.
// mode=0 runs one up-sweep and pulses done; mode=1 bounces between the
// endpoints until stop. Configuration is latched at start.
// Optional feature (macro DDS_SWEEP_PHASE_STEP_EN): adds port p_step and
// advances p_ctrl by p_step (mod 2^P_WORD_M) on every frequency step.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start, stop, mode        - sweep request, abort, 0=single/1=triangle
//   f_start, f_stop, f_step  - sweep endpoints and increment (FW bits)
//   dwell                    - cycles per frequency (0 acts as 1)
//   p_base                   - phase offset
//   p_step                   - phase increment (only with the macro)
//   f_ctrl, p_ctrl           - registered frequency and phase words
//   busy, done, dir          - sweep active, single-sweep done pulse, down leg
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int F_WORD_N = DEF_F_WORD_N,
  parameter int P_WORD_M = DEF_P_WORD_M,
  parameter int DWELL_W  = DEF_DWELL_W,
  localparam int FW      = F_WORD_N - P_WORD_M
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic [FW-1:0]       f_start,
  input  logic [FW-1:0]       f_stop,
  input  logic [FW-1:0]       f_step,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [P_WORD_M-1:0] p_base,
`ifdef DDS_SWEEP_PHASE_STEP_EN
  input  logic [P_WORD_M-1:0] p_step,
`endif
  output logic [FW-1:0]       f_ctrl,
  output logic [P_WORD_M-1:0] p_ctrl,
  output logic                busy,
  output logic                done,
  output logic                dir
);

  sweep_state_t        state_r, state_s;
  logic [FW-1:0]       f_start_r, f_stop_r, f_step_r;
  logic [DWELL_W-1:0]  dwell_r;
  logic                mode_r;
  logic [FW-1:0]       f_ctrl_r, f_ctrl_s;
  logic [P_WORD_M-1:0] p_ctrl_r, p_ctrl_s, p_adv_s;
  logic                busy_r, busy_s, done_r, done_s, dir_r, dir_s;
  logic                latch_s, tmr_load_s, expire_s;
  logic [DWELL_W-1:0]  tmr_dwell_s;
  logic [FW:0]         sum_s, diff_s;
  logic                up_hit_s, dn_hit_s;

  // One extra bit so the up step cannot wrap and the down step exposes a borrow.
  assign sum_s    = {1'b0, f_ctrl_r} + {1'b0, f_step_r};
  assign diff_s   = {1'b0, f_ctrl_r} - {1'b0, f_step_r};
  assign up_hit_s = (sum_s >= {1'b0, f_stop_r});
  assign dn_hit_s = diff_s[FW] || (diff_s[FW-1:0] <= f_start_r);

`ifdef DDS_SWEEP_PHASE_STEP_EN
  logic [P_WORD_M-1:0] p_step_r;

  // Phase increment is latched with the rest of the sweep configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_step_r <= '0;
    end else if (latch_s) begin
      p_step_r <= p_step;
    end else begin
      p_step_r <= p_step_r;
    end
  end

  assign p_adv_s = p_ctrl_r + p_step_r;
`else
  assign p_adv_s = p_ctrl_r;
`endif

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load_s),
    .dwell  (tmr_dwell_s),
    .expire (expire_s)
  );

  // Next-state and next-output logic; stop overrides everything outside IDLE.
  always_comb begin
    state_s     = state_r;
    f_ctrl_s    = f_ctrl_r;
    p_ctrl_s    = p_ctrl_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    dir_s       = dir_r;
    latch_s     = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_dwell_s = dwell_r;
    if ((state_r != IDLE) && stop) begin
      state_s = IDLE;
      busy_s  = 1'b0;
      dir_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            latch_s     = 1'b1;
            state_s     = UP;
            f_ctrl_s    = f_start;
            p_ctrl_s    = p_base;
            busy_s      = 1'b1;
            dir_s       = 1'b0;
            tmr_load_s  = 1'b1;
            tmr_dwell_s = dwell;
          end else begin
            state_s = IDLE;
          end
        end
        UP: begin
          if (expire_s) begin
            tmr_load_s = 1'b1;
            p_ctrl_s   = p_adv_s;
            if (up_hit_s) begin
              f_ctrl_s = f_stop_r;
              if (mode_r) begin
                state_s = DOWN;
                dir_s   = 1'b1;
              end else begin
                state_s = FINISH;
                done_s  = 1'b1;
              end
            end else begin
              f_ctrl_s = sum_s[FW-1:0];
            end
          end else begin
            state_s = UP;
          end
        end
        DOWN: begin
          if (expire_s) begin
            tmr_load_s = 1'b1;
            p_ctrl_s   = p_adv_s;
            if (dn_hit_s) begin
              f_ctrl_s = f_start_r;
              dir_s    = 1'b0;
              state_s  = UP;
            end else begin
              f_ctrl_s = diff_s[FW-1:0];
            end
          end else begin
            state_s = DOWN;
          end
        end
        FINISH: begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
          dir_s   = 1'b0;
        end
      endcase
    end
  end

  // State, output and latched-configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      f_ctrl_r  <= '0;
      p_ctrl_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dir_r     <= 1'b0;
      f_start_r <= '0;
      f_stop_r  <= '0;
      f_step_r  <= '0;
      dwell_r   <= '0;
      mode_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      f_ctrl_r <= f_ctrl_s;
      p_ctrl_r <= p_ctrl_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      dir_r    <= dir_s;
      if (latch_s) begin
        f_start_r <= f_start;
        f_stop_r  <= f_stop;
        f_step_r  <= f_step;
        dwell_r   <= dwell;
        mode_r    <= mode;
      end else begin
        f_start_r <= f_start_r;
        f_stop_r  <= f_stop_r;
        f_step_r  <= f_step_r;
        dwell_r   <= dwell_r;
        mode_r    <= mode_r;
      end
    end
  end

  assign f_ctrl = f_ctrl_r;
  assign p_ctrl = p_ctrl_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign dir    = dir_r;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Self-checking bench for dds_sweep_ctrl with default parameters (FW = 20).
// Each task pushes the expected per-cycle outputs {f_ctrl,p_ctrl,busy,done,dir}
// into a queue, then drives the stimulus and pops one entry per clock.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

  localparam int FW = 20;
  localparam int PW = 12;
  localparam int DW = 16;

  typedef struct packed {
    logic [FW-1:0] f;
    logic [PW-1:0] p;
    logic          b;
    logic          d;
    logic          r;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, stop, mode;
  logic [FW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] p_base;
`ifdef DDS_SWEEP_PHASE_STEP_EN
  logic [PW-1:0] p_step;
`endif
  logic [FW-1:0] f_ctrl;
  logic [PW-1:0] p_ctrl;
  logic          busy, done, dir;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  dds_sweep_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .p_base  (p_base),
`ifdef DDS_SWEEP_PHASE_STEP_EN
    .p_step  (p_step),
`endif
    .f_ctrl  (f_ctrl),
    .p_ctrl  (p_ctrl),
    .busy    (busy),
    .done    (done),
    .dir     (dir)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [FW-1:0] f, input logic [PW-1:0] p,
                      input logic b, input logic d, input logic r, input int n);
    exp_t e;
    e = {f, p, b, d, r};
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  task automatic cfg(input logic m, input int fs, input int fe, input int st,
                     input int dw, input int pb);
    mode    = m;
    f_start = FW'(fs);
    f_stop  = FW'(fe);
    f_step  = FW'(st);
    dwell   = DW'(dw);
    p_base  = PW'(pb);
  endtask

  task automatic test_reset();
    exp_t e;
    int   i;
    cfg(1'b0, 7, 9, 1, 1, 5);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    push('0, '0, 1'b0, 1'b0, 1'b0, 3);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 2) begin rst = 1'b0; start = 1'b0; stop = 1'b0; end
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL reset cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_single();
    exp_t e;
    int   i;
    cfg(1'b0, 100, 130, 10, 4, 9);
    push(100, 9, 1'b1, 1'b0, 1'b0, 4);
    push(110, 9, 1'b1, 1'b0, 1'b0, 4);
    push(120, 9, 1'b1, 1'b0, 1'b0, 4);
    push(130, 9, 1'b1, 1'b1, 1'b0, 1);
    push(130, 9, 1'b0, 1'b0, 1'b0, 3);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL single cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_clamp();
    exp_t e;
    int   i;
    cfg(1'b0, 0, 25, 10, 1, 0);
    push(0,  0, 1'b1, 1'b0, 1'b0, 1);
    push(10, 0, 1'b1, 1'b0, 1'b0, 1);
    push(20, 0, 1'b1, 1'b0, 1'b0, 1);
    push(25, 0, 1'b1, 1'b1, 1'b0, 1);
    push(25, 0, 1'b0, 1'b0, 1'b0, 2);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL clamp cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_triangle();
    exp_t e;
    int   i;
    cfg(1'b1, 0, 20, 10, 1, 3);
    push(0,  3, 1'b1, 1'b0, 1'b0, 1);
    push(10, 3, 1'b1, 1'b0, 1'b0, 1);
    push(20, 3, 1'b1, 1'b0, 1'b1, 1);
    push(10, 3, 1'b1, 1'b0, 1'b1, 1);
    push(0,  3, 1'b1, 1'b0, 1'b0, 1);
    push(10, 3, 1'b1, 1'b0, 1'b0, 1);
    push(20, 3, 1'b1, 1'b0, 1'b1, 1);
    push(10, 3, 1'b1, 1'b0, 1'b1, 1);
    push(10, 3, 1'b0, 1'b0, 1'b0, 2);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      if (i == 8) stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL triangle cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    int   i;
    cfg(1'b1, 5, 1048575, 524288, 1, 0);
    push(5,       0, 1'b1, 1'b0, 1'b0, 1);
    push(524293,  0, 1'b1, 1'b0, 1'b0, 1);
    push(1048575, 0, 1'b1, 1'b0, 1'b1, 1);
    push(524287,  0, 1'b1, 1'b0, 1'b1, 1);
    push(5,       0, 1'b1, 1'b0, 1'b0, 1);
    push(524293,  0, 1'b1, 1'b0, 1'b0, 1);
    push(524293,  0, 1'b0, 1'b0, 1'b0, 1);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      if (i == 6) stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL underflow cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   i;
    // Stop in the third dwell; a mid-sweep start with a new config is ignored,
    // and start together with stop in IDLE stays idle.
    cfg(1'b0, 100, 130, 10, 4, 9);
    push(100, 9, 1'b1, 1'b0, 1'b0, 4);
    push(110, 9, 1'b1, 1'b0, 1'b0, 4);
    push(120, 9, 1'b1, 1'b0, 1'b0, 1);
    push(120, 9, 1'b0, 1'b0, 1'b0, 5);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      if (i == 5) begin start = 1'b1; cfg(1'b1, 500, 900, 1, 1, 77); end
      if (i == 9) stop = 1'b1;
      if (i == 11) begin start = 1'b1; stop = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL abort cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
    // Reset in the middle of a sweep clears every output, start notwithstanding.
    cfg(1'b0, 100, 130, 10, 4, 9);
    push(100, 9, 1'b1, 1'b0, 1'b0, 4);
    push(110, 9, 1'b1, 1'b0, 1'b0, 1);
    push(0,   0, 1'b0, 1'b0, 1'b0, 3);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      if (i == 5) begin rst = 1'b1; start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; rst = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL abort_rst cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    int   i;
    // f_start above f_stop with dwell 0: one-cycle dwell, then clamp and done.
    cfg(1'b0, 50, 40, 3, 0, 1);
    push(50, 1, 1'b1, 1'b0, 1'b0, 1);
    push(40, 1, 1'b1, 1'b1, 1'b0, 1);
    push(40, 1, 1'b0, 1'b0, 1'b0, 2);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL inverted cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
    // Zero step: parked on f_start until stop.
    cfg(1'b0, 10, 20, 0, 2, 2);
    push(10, 2, 1'b1, 1'b0, 1'b0, 6);
    push(10, 2, 1'b0, 1'b0, 1'b0, 2);
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      if (i == 6) stop = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL zero_step cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
  endtask

  task automatic test_phase();
    exp_t e;
    int   i;
    cfg(1'b0, 0, 20, 10, 1, 4090);
`ifdef DDS_SWEEP_PHASE_STEP_EN
    p_step = 12'd4;
    push(0,  4090, 1'b1, 1'b0, 1'b0, 1);
    push(10, 4094, 1'b1, 1'b0, 1'b0, 1);
    push(20, 2,    1'b1, 1'b1, 1'b0, 1);
    push(20, 2,    1'b0, 1'b0, 1'b0, 2);
`else
    push(0,  4090, 1'b1, 1'b0, 1'b0, 1);
    push(10, 4090, 1'b1, 1'b0, 1'b0, 1);
    push(20, 4090, 1'b1, 1'b1, 1'b0, 1);
    push(20, 4090, 1'b0, 1'b0, 1'b0, 2);
`endif
    i = 0;
    while (exp_q.size() != 0) begin
      if (i == 0) start = 1'b1;
      if (i == 1) p_base = 12'd5;
      @(posedge clk); #1;
      start = 1'b0;
      e = exp_q.pop_front(); n_cmp++;
      if ({f_ctrl, p_ctrl, busy, done, dir} !== e)
        begin n_err++; $display("FAIL phase cyc %0d: got f=%0d p=%0d bdr=%b%b%b want f=%0d p=%0d bdr=%b%b%b",
          i, f_ctrl, p_ctrl, busy, done, dir, e.f, e.p, e.b, e.d, e.r); end
      i++;
    end
`ifdef DDS_SWEEP_PHASE_STEP_EN
    p_step = 12'd0;
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
`ifdef DDS_SWEEP_PHASE_STEP_EN
    p_step = 12'd0;
`endif
    cfg(1'b0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_clamp();
    test_triangle();
    test_underflow();
    test_abort();
    test_boundary();
    test_phase();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
